dpc_linebuf_ctrl: RTL

DPC_LINEBUF_CTRL -- requirements
Module: dpc_linebuf_ctrl

---
 rtl/dpc_pkg.sv | 18 +
 rtl/dpc_xy_cnt.sv | 49 ++++
 rtl/dpc_linebuf_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dpc_pkg.sv
// Shared types and constants for the DPC line-buffer controller.
package dpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef logic [9:0]  coord_t;
    typedef logic [11:0] shcnt_t;

    // Shifts needed before the first window centre reaches the middle tap.
    function automatic int fill_f(input int img_w, input int win);
        return (win / 2) * img_w + (win / 2);
    endfunction

endpackage

// File: rtl/dpc_xy_cnt.sv
// Raster x/y position counter; clear and enable in the same cycle counts from (0,0).
module dpc_xy_cnt
    import dpc_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 512
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en_i,
    input  logic   clr_i,
    output coord_t x_o,
    output coord_t y_o
);

    localparam coord_t X_MAX = coord_t'(IMG_W - 1);
    localparam coord_t Y_MAX = coord_t'(IMG_H - 1);

    coord_t x_q, y_q, x_d, y_d, base_x, base_y;

    always_comb begin
        base_x = clr_i ? '0 : x_q;
        base_y = clr_i ? '0 : y_q;
        x_d    = base_x;
        y_d    = base_y;
        if (en_i) begin
            if (base_x == X_MAX) begin
                x_d = '0;
                y_d = (base_y == Y_MAX) ? '0 : base_y + 10'd1;
            end else begin
                x_d = base_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/dpc_linebuf_ctrl.sv
// Line-buffer sequencing for the DPC window: feeds the buffer chain, flushes with padding
// and tracks window-centre coordinates. Optional err_len detection: DPC_LBCTRL_ERR_EN.
module dpc_linebuf_ctrl
    import dpc_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 512,
    parameter int WIN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic       pix_sof,
    output logic       lb_shift,
    output logic       pad_sel,
    output logic       win_valid,
    output coord_t     ctr_x,
    output coord_t     ctr_y,
    output logic [3:0] bdr,
    output logic       frame_done,
    output logic       busy,
    output logic       err_len,
    output state_e     dbg_state
);

    localparam int     H       = WIN / 2;
    localparam shcnt_t FILL_C  = shcnt_t'(fill_f(IMG_W, WIN));
    localparam shcnt_t FILL_M1 = shcnt_t'(fill_f(IMG_W, WIN) - 1);
    localparam coord_t H_C     = coord_t'(H);
    localparam coord_t X_MAX   = coord_t'(IMG_W - 1);
    localparam coord_t Y_MAX   = coord_t'(IMG_H - 1);
    localparam coord_t X_HI    = coord_t'(IMG_W - 1 - H);
    localparam coord_t Y_HI    = coord_t'(IMG_H - 1 - H);

    state_e     state_q, state_d;
    shcnt_t     k_q, k_d, k_cur, fl_q, fl_d;
    logic       win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic [3:0] bdr_q, bdr_d;
    coord_t     ctr_x_q, ctr_y_q, in_x, in_y, cx, cy;
    logic       start, abort, restart, shift, pad, accept, in_last, flush_last;

    assign start      = (state_q == IDLE) && pix_valid && pix_sof;
    assign abort      = (state_q == RUN) && pix_valid && pix_sof;
    assign restart    = start || abort;
    assign accept     = shift && !pad;
    assign in_last    = (in_x == X_MAX) && (in_y == Y_MAX);
    assign flush_last = (fl_q == FILL_M1);

    always_comb begin
        state_d      = state_q;
        shift        = 1'b0;
        pad          = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = pix_valid;
                if (pix_valid && !pix_sof && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                shift = 1'b1;
                pad   = 1'b1;
                if (flush_last) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // k saturates at FILL: from there on every shift releases one centre pixel.
    always_comb begin
        k_cur       = restart ? '0 : k_q;
        win_valid_d = shift && (k_cur >= FILL_C);
        k_d         = k_q;
        if (shift) k_d = win_valid_d ? FILL_C : k_cur + 12'd1;
        fl_d        = ((state_q == FLUSH) && !flush_last) ? fl_q + 12'd1 : '0;
        bdr_d       = '0;
        if (win_valid_d) bdr_d = {cy > Y_HI, cy < H_C, cx > X_HI, cx < H_C};
    end

    dpc_xy_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_in_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (accept),
        .clr_i (restart),
        .x_o   (in_x),
        .y_o   (in_y)
    );

    // Holds the position of the next centre to be issued.
    dpc_xy_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_ctr_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (win_valid_d),
        .clr_i (restart),
        .x_o   (cx),
        .y_o   (cy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            fl_q         <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bdr_q        <= '0;
            ctr_x_q      <= '0;
            ctr_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fl_q         <= fl_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            bdr_q        <= bdr_d;
            if (win_valid_d) begin
                ctr_x_q <= cx;
                ctr_y_q <= cy;
            end
        end
    end

`ifdef DPC_LBCTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (abort || ((state_q == FLUSH) && pix_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err_len = err_q;
`else
    assign err_len = 1'b0;
`endif

    assign lb_shift   = shift && !reset;
    assign pad_sel    = pad && !reset;
    assign win_valid  = win_valid_q;
    assign ctr_x      = ctr_x_q;
    assign ctr_y      = ctr_y_q;
    assign bdr        = bdr_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule
